// File: rtl/ann_label_pkg.sv
// rtl/ann_label_pkg.sv - shared width helpers and label types for the target label buffer
package ann_label_pkg;

  localparam int DEF_N    = 10;
  localparam int DEF_FX_W = 16;

  // Width of a class index; never narrower than one bit.
  function automatic int cls_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Width of a FIFO pointer for a power-of-two depth.
  function automatic int ptr_width(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  // Width of an occupancy count that must reach depth itself.
  function automatic int lvl_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int DEF_CLS_W = cls_width(DEF_N);

  typedef logic [DEF_CLS_W-1:0] class_idx_t;
  typedef logic [DEF_FX_W-1:0]  target_elem_t;

endpackage

// File: rtl/label_fifo.sv
// rtl/label_fifo.sv - class-index FIFO with flush, pointers wrap modulo DEPTH
module label_fifo
  import ann_label_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int W     = 4,
  localparam int PTR_W = ptr_width(DEPTH),
  localparam int CNT_W = lvl_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem [0:DEPTH-1];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  // Storage array: written on push only, contents are don't-care when empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; flush drops everything regardless of push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/target_label_buffer.sv
// rtl/target_label_buffer.sv - buffers class indices and presents one-hot labels with fixed-point targets
module target_label_buffer
  import ann_label_pkg::*;
#(
  parameter  int             layers = 3,
  parameter  int             rows [0:layers-1] = '{50, 30, 10},
  parameter  int             DEPTH = 4,
  parameter  int             FX_W = 16,
  parameter  logic [FX_W-1:0] HOT_VAL = 16'h0E66,
  parameter  logic [FX_W-1:0] COLD_VAL = 16'h001C,
  localparam int             N = rows[layers-1],
  localparam int             CLS_W = cls_width(N),
  localparam int             LVL_W = lvl_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CLS_W-1:0]  in_class,
  input  logic              flush,
  input  logic              clear_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_label,
  output logic [N*FX_W-1:0] out_target,
  output logic [LVL_W-1:0]  level,
  output logic              err_flag,
  output logic [15:0]       err_cnt
);

  logic             accept;
  logic             bad_class;
  logic             push_ok;
  logic             pop_out;
  logic             load;
  logic             fifo_empty;
  logic [CLS_W-1:0] fifo_head;
  logic [LVL_W-1:0] fifo_count;
  logic [CLS_W-1:0] cls_q;

  // Occupancy counts the FIFO plus the label sitting in the output register;
  // both terms are registers, so a same-cycle pop cannot raise in_ready.
  assign level     = fifo_count + LVL_W'(out_valid);
  assign in_ready  = (level < LVL_W'(DEPTH));
  assign accept    = in_valid && in_ready;
  // Extra bit keeps the compare correct when N is an exact power of two.
  assign bad_class = accept && ({1'b0, in_class} >= (CLS_W+1)'(N));
  assign push_ok   = accept && !bad_class && !flush;
  assign pop_out   = out_valid && out_ready;
  assign load      = !flush && (!out_valid || pop_out) && !fifo_empty;

  label_fifo #(
    .DEPTH (DEPTH),
    .W     (CLS_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push_ok),
    .push_data (in_class),
    .pop       (load),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Output register: refills from the FIFO head whenever it is empty or being consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      cls_q     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (!out_valid || pop_out) begin
      out_valid <= !fifo_empty;
      if (!fifo_empty) begin
        cls_q <= fifo_head;
      end
    end
  end

  // Error state: an out-of-range accept beats a same-cycle clear; count saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_flag <= 1'b0;
      err_cnt  <= '0;
    end else if (bad_class) begin
      err_flag <= 1'b1;
      if (clear_err) begin
        err_cnt <= 16'd1;
      end else if (err_cnt != 16'hFFFF) begin
        err_cnt <= err_cnt + 16'd1;
      end
    end else if (clear_err) begin
      err_flag <= 1'b0;
      err_cnt  <= '0;
    end
  end

  // One-hot label and target decode from the held index; all zeros when idle.
  always_comb begin
    out_label  = '0;
    out_target = '0;
    if (out_valid) begin
      for (int i = 0; i < N; i++) begin
        out_label[i]               = (cls_q == CLS_W'(i));
        out_target[i*FX_W +: FX_W] = (cls_q == CLS_W'(i)) ? HOT_VAL : COLD_VAL;
      end
    end
  end

endmodule

// File: doc/target_label_buffer.md
TARGET_LABEL_BUFFER -- requirements
Module: target_label_buffer

Interface
REQ-001 SHALL have parameter layers, default 3, meaning the number of network layers.
REQ-002 SHALL have parameter int rows[0:layers-1], default '{50,30,10}; N = rows[layers-1] is the class count.
REQ-003 SHALL have parameter DEPTH, default 4, meaning total label capacity (power of 2, >=2).
REQ-004 SHALL have parameter FX_W, default 16, meaning fixed-point width of each target element.
REQ-005 SHALL have parameters HOT_VAL, default 16'h0E66, and COLD_VAL, default 16'h001C, meaning target values for the hot and cold classes.
REQ-006 Ports (CLS_W = max(1,$clog2(N))); the one clock, reset asynchronous active-low:
  clk        in   1        clock, all state on rising edge
  rst_n      in   1        asynchronous active-low reset
  in_valid   in   1        class index offered
  in_ready   out  1        buffer can accept
  in_class   in   CLS_W    class index
  flush      in   1        synchronous clear of buffered labels
  clear_err  in   1        synchronous clear of error state
  out_valid  out  1        label available
  out_ready  in   1        consumer accepts label
  out_label  out  N        one-hot label
  out_target out  N*FX_W   fixed-point target vector, element i at [i*FX_W +: FX_W]
  level      out  $clog2(DEPTH+1)  labels held (FIFO plus output register)
  err_flag   out  1        sticky out-of-range indicator
  err_cnt    out  16       saturating out-of-range count

Function
REQ-007 Input SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-008 in_ready SHALL equal (level < DEPTH), derived from registered state only; a simultaneous pop SHALL NOT raise it in the same cycle.
REQ-009 An accepted in_class >= N SHALL be dropped (not stored); err_flag SHALL set and err_cnt SHALL increment, saturating at 16'hFFFF.
REQ-010 In-range classes SHALL be stored as indices in FIFO order; no reordering, no duplication.
REQ-011 With the buffer empty, a class accepted on edge k SHALL produce out_valid=1 after edge k+1 (1-cycle latency).
REQ-012 out_label SHALL hold exactly bit[class]=1; out_target element[class]=HOT_VAL and all other elements=COLD_VAL.
REQ-013 A label SHALL be consumed on an edge where out_valid && out_ready; the next FIFO entry SHALL load the output register on that same edge (back-to-back throughput 1/cycle).
REQ-014 While out_valid && !out_ready, out_label, out_target and out_valid SHALL remain stable.
REQ-015 When out_valid=0, out_label and out_target SHALL be all zeros.
REQ-016 Simultaneous accept and consume SHALL leave level unchanged; level SHALL never exceed DEPTH or underflow.
REQ-017 flush SHALL empty the buffer on the next edge (level=0, out_valid=0) and SHALL take priority over a same-cycle push or pop; the error state SHALL be retained.
REQ-018 clear_err SHALL zero err_flag and err_cnt; a same-cycle out-of-range accept SHALL win (err_cnt=1, err_flag=1).
REQ-019 FIFO pointers SHALL wrap modulo DEPTH without loss.

Reset
REQ-020 rst_n low SHALL asynchronously clear pointers, level, out_valid, err_flag and err_cnt; out_label and out_target SHALL read zero.
REQ-021 in_ready SHALL be 1 from the first edge after rst_n release; reset mid-stream SHALL discard all held labels.

Structure
REQ-022 Shared package ann_label_pkg SHALL hold the class-index and target-element typedefs and the clog2-based width helpers.
REQ-023 Storage SHALL be one sub-module label_fifo (index FIFO, depth DEPTH-1 or DEPTH); the one-hot/target decode and output register SHALL sit in target_label_buffer.

Verification (N=10, DEPTH=4, defaults)
REQ-024 Reset: rst_n=0 -> out_valid=0, level=0, err_cnt=0, out_label=10'b0; after release in_ready=1.
REQ-025 Push 3 with out_ready=1 -> next cycle out_valid=1, out_label=10'b0000001000, element3=16'h0E66, others=16'h001C.
REQ-026 Push 10 then 15 -> nothing output, err_flag=1, err_cnt=2; clear_err -> err_cnt=0.
REQ-027 out_ready=0, push 1,2,3,4,5 -> first four accepted, level=4, in_ready=0; then out_ready=1 -> labels 1,2,3,4 emitted in consecutive cycles.
REQ-028 Push 7,9 then flush with concurrent push 0 -> level=0, out_valid=0, no label 0 emitted.
REQ-029 rst_n pulsed low while level=3 -> immediate out_valid=0, level=0; subsequent push 6 emits bit6 only.
